// File: rtl/wide_shift_seq_if.sv
// Port bundle for the multi-byte shift sequencer: byte load, start/shift control, byte read-back and status.
// The Arith input exists only when WIDE_SHIFT_ARITH_EN is defined.
interface wide_shift_seq_if #(
    parameter int NBYTES = 4,
    parameter int IDXW   = $clog2(NBYTES)
);
    logic            load;
    logic [IDXW-1:0] load_idx;
    logic [7:0]      load_data;
    logic            start;
    logic            dir;
    logic [2:0]      shamt;
`ifdef WIDE_SHIFT_ARITH_EN
    logic            arith;
`endif
    logic [IDXW-1:0] rd_idx;
    logic [7:0]      rd_data;
    logic            busy;
    logic            done;
    logic [7:0]      carry_out;

    modport master (
        output load, load_idx, load_data, start, dir, shamt,
`ifdef WIDE_SHIFT_ARITH_EN
        output arith,
`endif
        output rd_idx,
        input  rd_data, busy, done, carry_out
    );

    modport slave (
        input  load, load_idx, load_data, start, dir, shamt,
`ifdef WIDE_SHIFT_ARITH_EN
        input  arith,
`endif
        input  rd_idx,
        output rd_data, busy, done, carry_out
    );
endinterface

// File: rtl/wide_shift_seq.sv
// Multi-byte shift sequencer: shifts an NBYTES-wide buffer by 0-7 bits, one byte per cycle, carrying bits between bytes.
// Define WIDE_SHIFT_ARITH_EN to enable sign-filling arithmetic right shifts via the arith input.
module wide_shift_seq #(
    parameter int NBYTES = 4,
    parameter int IDXW   = $clog2(NBYTES)
) (
    input  logic              clk,
    input  logic              rst,
    wide_shift_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [7:0]      buffer_reg [NBYTES];
    logic [IDXW-1:0] ctr_reg;
    logic [7:0]      carry_reg;
    logic [7:0]      carry_out_reg;
    logic            dir_reg;
    logic [2:0]      shamt_reg;

    logic            accept_start;
    logic            accept_load;
    logic            in_shift;
    logic            last_byte;
    logic [7:0]      cur_byte;
    logic [15:0]     left_wide;
    logic [15:0]     right_wide;
    logic [7:0]      shift_byte;
    logic [7:0]      carry_next;
    logic [7:0]      start_carry;
    logic [7:0]      byte_wdata;
    logic [NBYTES-1:0] byte_we;

    assign accept_start = (state_reg == IDLE) && bus.start;
    assign accept_load  = (state_reg == IDLE) && bus.load && !bus.start;
    assign in_shift     = (state_reg == SHIFT);

    // Shifting through a 16-bit window yields the shifted byte and the
    // outgoing carry together; Shamt = 0 naturally gives a zero carry.
    always_comb begin
        cur_byte   = buffer_reg[ctr_reg];
        left_wide  = {8'h00, cur_byte} << shamt_reg;
        right_wide = {cur_byte, 8'h00} >> shamt_reg;
        if (dir_reg) begin
            shift_byte = right_wide[15:8] | carry_reg;
            carry_next = right_wide[7:0];
            last_byte  = (ctr_reg == '0);
        end else begin
            shift_byte = left_wide[7:0] | carry_reg;
            carry_next = left_wide[15:8];
            last_byte  = (ctr_reg == IDXW'(NBYTES - 1));
        end
    end

`ifdef WIDE_SHIFT_ARITH_EN
    logic [15:0] fill_wide;
    always_comb begin
        fill_wide   = 16'hFF00 >> bus.shamt;
        start_carry = 8'h00;
        if (bus.dir && bus.arith && buffer_reg[NBYTES-1][7])
            start_carry = fill_wide[7:0];
    end
`else
    assign start_carry = 8'h00;
`endif

    assign byte_wdata = in_shift ? shift_byte : bus.load_data;

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte_we
            assign byte_we[gi] = (accept_load && (bus.load_idx == IDXW'(gi))) ||
                                 (in_shift && (ctr_reg == IDXW'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBYTES; i++)
                buffer_reg[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NBYTES; i++)
                if (byte_we[i])
                    buffer_reg[i] <= byte_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr_reg       <= '0;
            carry_reg     <= 8'h00;
            carry_out_reg <= 8'h00;
            dir_reg       <= 1'b0;
            shamt_reg     <= 3'd0;
        end else if (accept_start) begin
            dir_reg   <= bus.dir;
            shamt_reg <= bus.shamt;
            carry_reg <= start_carry;
            ctr_reg   <= bus.dir ? IDXW'(NBYTES - 1) : '0;
        end else if (in_shift) begin
            carry_reg <= carry_next;
            if (last_byte)
                carry_out_reg <= carry_next;
            else if (dir_reg)
                ctr_reg <= ctr_reg - 1'b1;
            else
                ctr_reg <= ctr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last_byte) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy      = (state_reg == SHIFT);
    assign bus.done      = (state_reg == DONE);
    assign bus.carry_out = carry_out_reg;
    assign bus.rd_data   = (32'(bus.rd_idx) < NBYTES) ? buffer_reg[bus.rd_idx] : 8'h00;

endmodule

// File: tb/tb_wide_shift_seq.sv
// Self-checking bench for wide_shift_seq: directed spec cases plus random shifts against a 32-bit arithmetic model.
// Arithmetic-fill cases run only when WIDE_SHIFT_ARITH_EN is defined.
module tb_wide_shift_seq;
    localparam int NBYTES = 4;
    localparam int IDXW   = 2;
    localparam int LAT    = NBYTES + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wide_shift_seq_if #(.NBYTES(NBYTES), .IDXW(IDXW)) bus ();

    wide_shift_seq #(.NBYTES(NBYTES), .IDXW(IDXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Whole-operand reference: the byte-serial carry chain equals a plain wide shift.
    function automatic void model(input logic [31:0] v, input bit d, input int s, input bit a,
                                  output logic [31:0] r, output logic [7:0] c);
        logic [39:0] f;
        if (!d) begin
            f = {8'h00, v} << s;
            r = f[31:0];
            c = f[39:32];
        end else begin
            f = {v, 8'h00} >> s;
            r = f[39:8];
            c = f[7:0];
            if (a && v[31]) r = r | ~(32'hFFFF_FFFF >> s);
        end
    endfunction

    task automatic idle_inputs();
        bus.load = 0; bus.load_idx = '0; bus.load_data = 8'h00;
        bus.start = 0; bus.dir = 0; bus.shamt = 3'd0; bus.rd_idx = '0;
`ifdef WIDE_SHIFT_ARITH_EN
        bus.arith = 0;
`endif
    endtask

    task automatic load_value(input logic [31:0] v);
        for (int i = 0; i < NBYTES; i++) begin
            bus.load = 1; bus.load_idx = IDXW'(i); bus.load_data = v[8*i +: 8];
            @(negedge clk);
        end
        bus.load = 0;
    endtask

    task automatic read_value(output logic [31:0] v);
        for (int i = 0; i < NBYTES; i++) begin
            bus.rd_idx = IDXW'(i);
            #1;
            v[8*i +: 8] = bus.rd_data;
        end
    endtask

    // Pulses start and waits (bounded) for done; returns the done latency and busy-cycle count.
    task automatic run_shift(input bit d, input int s, input bit a, output int lat, output int busy_n);
        bus.start = 1; bus.dir = d; bus.shamt = 3'(s);
`ifdef WIDE_SHIFT_ARITH_EN
        bus.arith = a;
`else
        if (a) $display("note: arith requested without arith support");
`endif
        @(negedge clk);
        bus.start = 0;
        lat = 0; busy_n = 0;
        for (int t = 1; t <= 20; t++) begin
            if (bus.done) begin lat = t; break; end
            if (bus.busy) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic check_shift(input string name, input logic [31:0] v, input bit d, input int s, input bit a);
        logic [31:0] exp_v, got_v;
        logic [7:0]  exp_c;
        int lat, busy_n;
        model(v, d, s, a, exp_v, exp_c);
        load_value(v);
        run_shift(d, s, a, lat, busy_n);
        read_value(got_v);
        n_cmp++;
        if (lat != LAT || busy_n != NBYTES) begin
            n_fail++;
            $display("FAIL %s latency: got done@%0d busy=%0d, want done@%0d busy=%0d", name, lat, busy_n, LAT, NBYTES);
        end
        n_cmp++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s value: got %h want %h", name, got_v, exp_v);
        end
        n_cmp++;
        if (bus.carry_out !== exp_c) begin
            n_fail++;
            $display("FAIL %s carry: got %h want %h", name, bus.carry_out, exp_c);
        end
        $display("%s: v=%h dir=%0d shamt=%0d arith=%0d -> %h carry %h", name, v, d, s, a, got_v, bus.carry_out);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.carry_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset outputs: busy=%b done=%b carry=%h, want 0 0 00", bus.busy, bus.done, bus.carry_out);
        end
        read_value(v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL reset buffer: got %h want 00000000", v);
        end
        $display("reset: buffer=%h", v);
    endtask

    task automatic test_directed();
        check_shift("case1", 32'h0000_1000, 0, 3, 0);
        check_shift("case2", 32'h8100_0000, 0, 4, 0);
        check_shift("case3a", 32'h0000_0100, 1, 1, 0);
        check_shift("case3b", 32'h0000_0003, 1, 2, 0);
        check_shift("zero_left", 32'hA5C3_7E19, 0, 0, 0);
        check_shift("zero_right", 32'h5A3C_E781, 1, 0, 0);
        check_shift("max_left", 32'hFFFF_FFFF, 0, 7, 0);
        check_shift("max_right", 32'hFFFF_FFFF, 1, 7, 0);
    endtask

    task automatic test_ignore_while_busy();
        logic [31:0] got_v, exp_v;
        logic [7:0]  exp_c;
        int lat;
        model(32'h1234_5678, 1, 3, 0, exp_v, exp_c);
        load_value(32'h1234_5678);
        bus.start = 1; bus.dir = 1; bus.shamt = 3'd3;
        @(negedge clk);
        bus.start = 0;
        // Second-cycle pulse of start and load while busy.
        @(negedge clk);
        bus.start = 1; bus.dir = 0; bus.shamt = 3'd5; bus.load = 1; bus.load_idx = 2'd0; bus.load_data = 8'hEE;
        @(negedge clk);
        bus.start = 0; bus.load = 0;
        lat = 0;
        for (int t = 3; t <= 20; t++) begin
            if (bus.done) begin lat = t; break; end
            @(negedge clk);
        end
        // Start and load during the done cycle are ignored too.
        bus.start = 1; bus.load = 1; bus.load_idx = 2'd3; bus.load_data = 8'h77;
        @(negedge clk);
        bus.start = 0; bus.load = 0;
        read_value(got_v);
        n_cmp++;
        if (lat != LAT) begin
            n_fail++;
            $display("FAIL ignore latency: got done@%0d want done@%0d", lat, LAT);
        end
        n_cmp++;
        if (got_v !== exp_v || bus.carry_out !== exp_c) begin
            n_fail++;
            $display("FAIL ignore result: got %h/%h want %h/%h", got_v, bus.carry_out, exp_v, exp_c);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore done-start: busy=%b want 0", bus.busy);
        end
        $display("ignore_while_busy: result %h carry %h", got_v, bus.carry_out);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        logic [31:0] v;
        int done_seen;
        load_value(32'hDEAD_BEEF);
        bus.start = 1; bus.dir = 0; bus.shamt = 3'd5;
        @(negedge clk);
        bus.start = 0;
        @(negedge clk);
        rst = 1;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset status: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        @(negedge clk);
        rst = 0;
        read_value(v);
        n_cmp++;
        if (v !== 32'h0 || bus.carry_out !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset buffer: got %h/%h want 00000000/00", v, bus.carry_out);
        end
        done_seen = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        n_cmp++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL midreset aftermath: %0d busy/done cycles want 0", done_seen);
        end
        $display("reset_mid_shift: buffer=%h", v);
    endtask

    task automatic test_random();
        logic [31:0] v;
        bit d, a;
        int s;
        for (int i = 0; i < 30; i++) begin
            v = $urandom;
            d = 1'($urandom_range(1));
            s = $urandom_range(7);
`ifdef WIDE_SHIFT_ARITH_EN
            a = 1'($urandom_range(1));
`else
            a = 0;
`endif
            check_shift($sformatf("rand%0d", i), v, d, s, a);
        end
    endtask

`ifdef WIDE_SHIFT_ARITH_EN
    task automatic test_arith();
        check_shift("arith_on", 32'h8000_0000, 1, 3, 1);
        check_shift("arith_off", 32'h8000_0000, 1, 3, 0);
        check_shift("arith_left", 32'h8000_00F1, 0, 3, 1);
        check_shift("arith_pos", 32'h7000_0001, 1, 5, 1);
    endtask
`endif

    initial begin
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_ignore_while_busy();
        test_reset_mid_shift();
        test_random();
`ifdef WIDE_SHIFT_ARITH_EN
        test_arith();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
